// File: rtl/pc_next_select.sv
// Next-PC selector (MUX_6): picks PC+1 or the MUX_5 branch/jump target, plus a registered redirect flag.
// Optional build macro MUX6_REG_OUT_EN registers MUX_6_out with a 1-cycle latency.
module pc_next_select #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         M6,
  input  logic [N-1:0] PC_plus_one,
  input  logic [N-1:0] MUX_5_out,
  output logic [N-1:0] MUX_6_out,
  output logic         redirect_q
);

  logic [N-1:0] sel_d;

  // An unknown select yields all-X instead of silently favouring either input.
  always_comb begin
    sel_d = 'x;
    case (M6)
      1'b0:    sel_d = PC_plus_one;
      1'b1:    sel_d = MUX_5_out;
      default: sel_d = 'x;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= M6;
    end
  end

`ifdef MUX6_REG_OUT_EN
  logic [N-1:0] mux6_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux6_q <= '0;
    end else begin
      mux6_q <= sel_d;
    end
  end

  assign MUX_6_out = mux6_q;
`else
  assign MUX_6_out = sel_d;
`endif

endmodule

// File: tb/tb_pc_next_select.sv
// Self-checking bench for pc_next_select: directed vector table, async-reset sequence, random run vs. reference model.
module tb_pc_next_select;
  localparam int unsigned N = 16;

  logic         clk;
  logic         rst_n;
  logic         M6;
  logic [N-1:0] PC_plus_one;
  logic [N-1:0] MUX_5_out;
  logic [N-1:0] MUX_6_out;
  logic         redirect_q;

  int checks;
  int errors;

  // Reference model state: what the block should be holding after the last edge.
  logic         mdl_redirect;
  logic [N-1:0] mdl_out_reg;

  typedef struct {
    logic         m6;
    logic [N-1:0] pcp1;
    logic [N-1:0] mux5;
    logic [N-1:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  pc_next_select #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .M6         (M6),
    .PC_plus_one(PC_plus_one),
    .MUX_5_out  (MUX_5_out),
    .MUX_6_out  (MUX_6_out),
    .redirect_q (redirect_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, check the combinational view, then check registered state after the rising edge.
  task automatic step(input string name, input logic m6, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [N-1:0] exp_sel);
    @(negedge clk);
    M6 = m6;
    PC_plus_one = a;
    MUX_5_out = b;
    #1;
`ifdef MUX6_REG_OUT_EN
    check({name, "_hold"}, MUX_6_out, mdl_out_reg);
`else
    check({name, "_comb"}, MUX_6_out, exp_sel);
`endif
    @(posedge clk);
    if (rst_n) begin
      mdl_redirect = m6;
      mdl_out_reg  = exp_sel;
    end
    #1;
    check({name, "_redirect"}, {{(N-1){1'b0}}, redirect_q}, {{(N-1){1'b0}}, mdl_redirect});
`ifdef MUX6_REG_OUT_EN
    check({name, "_reg"}, MUX_6_out, mdl_out_reg);
`else
    check({name, "_comb_post"}, MUX_6_out, exp_sel);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdl_redirect = 1'b0;
    mdl_out_reg  = '0;
    rst_n = 1'b0;
    M6 = 1'b1;
    PC_plus_one = 16'h1234;
    MUX_5_out = 16'h4321;

    vecs.push_back('{1'b0, 16'd10,   16'd20,   16'd10});
    vecs.push_back('{1'b1, 16'd10,   16'd20,   16'd20});
    vecs.push_back('{1'b1, 16'hFFFF, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF});
    vecs.push_back('{1'b1, 16'hFFFF, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 16'd10,   16'd20,   16'd10});
    vecs.push_back('{1'b0, 16'd11,   16'd99,   16'd11});
    vecs.push_back('{1'b1, 16'hAAAA, 16'h5555, 16'h5555});
    vecs.push_back('{1'b0, 16'h8000, 16'h0001, 16'h8000});
    vecs.push_back('{1'b1, 16'h0001, 16'hFFFF, 16'hFFFF});

    // Reset state while rst_n is held low across edges.
    #1;
    check("reset_redirect", {{(N-1){1'b0}}, redirect_q}, '0);
`ifdef MUX6_REG_OUT_EN
    check("reset_out", MUX_6_out, '0);
`else
    check("reset_out_comb", MUX_6_out, 16'h4321);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_redirect_held", {{(N-1){1'b0}}, redirect_q}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].m6, vecs[i].pcp1, vecs[i].mux5, vecs[i].exp_sel);

    // Async reset between edges with M6=1 held, then reload on the first edge after release.
    step("pre_rst", 1'b1, 16'd10, 16'd20, 16'd20);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mdl_redirect = 1'b0;
    mdl_out_reg  = '0;
    #1;
    check("async_rst_redirect", {{(N-1){1'b0}}, redirect_q}, '0);
`ifdef MUX6_REG_OUT_EN
    check("async_rst_out", MUX_6_out, '0);
`else
    check("async_rst_comb", MUX_6_out, 16'd20);
`endif
    step("in_rst", 1'b1, 16'd10, 16'd20, 16'd20);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 16'd10, 16'd20, 16'd20);

    // Random stimulus against the selection rule.
    for (int i = 0; i < 1000; i++) begin
      logic         m6;
      logic [N-1:0] a;
      logic [N-1:0] b;
      m6 = 1'($urandom_range(0, 1));
      a  = N'($urandom);
      b  = N'($urandom);
      step($sformatf("rnd%0d", i), m6, a, b, m6 ? b : a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
